// File: rtl/hazard_forward_unit_if.sv
// Decode-side request and hazard/forward response bundle for hazard_forward_unit.
// The unit takes the slave side; the decode stage (or bench) takes the master side.
interface hazard_forward_unit_if #(
    parameter int REG_ADDR_W  = 5,
    parameter int NUM_SRC     = 2,
    parameter int STALL_CNT_W = 32
);
    logic                          dec_valid;
    logic [NUM_SRC*REG_ADDR_W-1:0] dec_src_addr;
    logic [NUM_SRC-1:0]            dec_src_used;
    logic                          dec_rd_we;
    logic [REG_ADDR_W-1:0]         dec_rd_addr;
    logic                          dec_is_load;
    logic                          branch_flush;
    logic [NUM_SRC*2-1:0]          pipeline_forward_sel;
    logic                          f_to_d_enable_ff;
    logic                          f_to_d_flush;
    logic                          d_to_e_bubble;
    logic [STALL_CNT_W-1:0]        stall_cycles;

    modport master (
        output dec_valid, dec_src_addr, dec_src_used, dec_rd_we, dec_rd_addr, dec_is_load,
               branch_flush,
        input  pipeline_forward_sel, f_to_d_enable_ff, f_to_d_flush, d_to_e_bubble, stall_cycles
    );

    modport slave (
        input  dec_valid, dec_src_addr, dec_src_used, dec_rd_we, dec_rd_addr, dec_is_load,
               branch_flush,
        output pipeline_forward_sel, f_to_d_enable_ff, f_to_d_flush, d_to_e_bubble, stall_cycles
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding for the 5-stage pipeline, driven by a
// shadow scoreboard of EX/MEM/WB destinations.

// Per-operand resolver. Slot index 0 = EX, 1 = MEM, 2 = WB (youngest first).
module hfu_operand_resolve #(
    parameter int REG_ADDR_W = 5,
    parameter int FWD_ENABLE = 1
) (
    input  logic [REG_ADDR_W-1:0]      src,
    input  logic                       used,
    input  logic [2:0]                 slot_valid,
    input  logic [2:0]                 slot_we,
    input  logic [2:0][REG_ADDR_W-1:0] slot_rd,
    input  logic [1:0]                 slot_load,
    output logic [1:0]                 sel,
    output logic                       hazard
);
    logic [2:0] hit;

    always_comb begin
        for (int s = 0; s < 3; s++)
            hit[s] = slot_valid[s] && slot_we[s] && (slot_rd[s] == src) && (src != '0) && used;
    end

    always_comb begin
        sel    = 2'd0;
        hazard = 1'b0;
        if (FWD_ENABLE != 0) begin
            if (hit[0]) begin
                if (slot_load[0]) hazard = 1'b1;
                else              sel    = 2'd1;
            end else if (hit[1]) begin
                sel = slot_load[1] ? 2'd3 : 2'd2;
            end else if (hit[2]) begin
                // write-through register file already presents WB data
                sel = 2'd0;
            end
        end else begin
            hazard = hit[0] | hit[1];
        end
    end
endmodule

module hazard_forward_unit #(
    parameter int REG_ADDR_W  = 5,
    parameter int NUM_SRC     = 2,
    parameter int FWD_ENABLE  = 1,
    parameter int STALL_CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    hazard_forward_unit_if.slave  bus
);
    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic [REG_ADDR_W-1:0] rd;
        logic                  is_load;
    } slot_t;

    slot_t                    ex_q, mem_q, wb_q;
    logic [STALL_CNT_W-1:0]   stall_q;
    logic [NUM_SRC-1:0]       op_hazard;
    logic [NUM_SRC-1:0][1:0]  op_sel;
    logic                     stall;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_op
        hfu_operand_resolve #(
            .REG_ADDR_W (REG_ADDR_W),
            .FWD_ENABLE (FWD_ENABLE)
        ) u_res (
            .src        (bus.dec_src_addr[i*REG_ADDR_W +: REG_ADDR_W]),
            .used       (bus.dec_src_used[i]),
            .slot_valid ({wb_q.valid, mem_q.valid, ex_q.valid}),
            .slot_we    ({wb_q.we, mem_q.we, ex_q.we}),
            .slot_rd    ({wb_q.rd, mem_q.rd, ex_q.rd}),
            .slot_load  ({mem_q.is_load, ex_q.is_load}),
            .sel        (op_sel[i]),
            .hazard     (op_hazard[i])
        );
    end

    assign stall = bus.dec_valid && (|op_hazard);

    // flush outranks a hazard stall; reset forces a bubble with fetch running
    always_comb begin
        bus.pipeline_forward_sel = rst ? '0 : op_sel;
        bus.f_to_d_enable_ff     = 1'b1;
        bus.f_to_d_flush         = 1'b0;
        bus.d_to_e_bubble        = 1'b0;
        if (rst) begin
            bus.d_to_e_bubble = 1'b1;
        end else if (bus.branch_flush) begin
            bus.f_to_d_flush  = 1'b1;
            bus.d_to_e_bubble = 1'b1;
        end else if (stall) begin
            bus.f_to_d_enable_ff = 1'b0;
            bus.d_to_e_bubble    = 1'b1;
        end
    end

    assign bus.stall_cycles = stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            stall_q <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            if (bus.dec_valid && !stall && !bus.branch_flush)
                ex_q <= '{valid: 1'b1, we: bus.dec_rd_we, rd: bus.dec_rd_addr,
                          is_load: bus.dec_is_load};
            else
                ex_q <= '0;
            if (stall && !bus.branch_flush && !(&stall_q))
                stall_q <= stall_q + STALL_CNT_W'(1);
        end
    end
endmodule
